// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared types and helpers for the convolution block family.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } conv_state_t;

    // Never returns 0 so that counters for 1-wide images still get a bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : conv_line_buf
// Brief    : DEPTH-deep shift register; tap is the sample DEPTH beats old.
// Revision : 1.0 - initial release
// ============================================================================
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign tap = r_mem[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_gen
// Brief    : Raster-stream KERNEL x KERNEL sliding-window generator.
//            Optional macro CONV_WIN_LAST_EN adds the win_last output.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               pix_in,
    input  logic                       pix_valid,
    input  logic                       sof,
    output logic [KERNEL*KERNEL*N-1:0] data2conv,
    output logic                       en_out
`ifdef CONV_WIN_LAST_EN
    ,
    output logic                       win_last
`endif
);

    localparam int c_col_w = clog2(IMG_W);
    localparam int c_row_w = clog2(IMG_H);
    localparam logic [c_col_w-1:0] c_col_max  = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0] c_row_max  = c_row_w'(IMG_H - 1);
    localparam logic [c_col_w-1:0] c_col_full = c_col_w'(KERNEL - 1);
    localparam logic [c_row_w-1:0] c_row_full = c_row_w'(KERNEL - 1);

    logic [c_col_w-1:0] r_col, w_col_eff, w_col_nxt;
    logic [c_row_w-1:0] r_row, w_row_eff, w_row_nxt;
    logic               w_wrap;
    logic               w_emit;
    conv_state_t        r_state, w_state_next;

    logic [N-1:0]                w_new_col  [KERNEL];
    logic [N-1:0]                r_win      [KERNEL][KERNEL];
    logic [N-1:0]                w_win_next [KERNEL][KERNEL];
    logic [KERNEL*KERNEL*N-1:0]  w_win_flat;

    // Newest row enters from pix_in; older rows come from the line-buffer chain.
    assign w_new_col[KERNEL-1] = pix_in;

    generate
        if (KERNEL > 1) begin : g_lines
            logic [N-1:0] w_lb_in  [KERNEL-1];
            logic [N-1:0] w_lb_tap [KERNEL-1];
            for (genvar j = 0; j < KERNEL - 1; j++) begin : g_line
                if (j == 0) begin : g_first
                    assign w_lb_in[j] = pix_in;
                end else begin : g_chain
                    assign w_lb_in[j] = w_lb_tap[j-1];
                end
                conv_line_buf #(
                    .DEPTH (IMG_W),
                    .WIDTH (N)
                ) u_line_buf (
                    .clk (clk),
                    .en  (pix_valid),
                    .din (w_lb_in[j]),
                    .tap (w_lb_tap[j])
                );
                assign w_new_col[KERNEL-2-j] = w_lb_tap[j];
            end
        end
    endgenerate

    generate
        for (genvar r = 0; r < KERNEL; r++) begin : g_row
            for (genvar c = 0; c < KERNEL; c++) begin : g_col
                if (c < KERNEL - 1) begin : g_shift
                    assign w_win_next[r][c] = r_win[r][c+1];
                end else begin : g_load
                    assign w_win_next[r][c] = w_new_col[r];
                end
                assign w_win_flat[win_idx(r, c, KERNEL)*N +: N] = w_win_next[r][c];
            end
        end
    endgenerate

    // sof forces the accepted beat to (0,0) whatever the counters say.
    always_comb begin
        w_col_eff = sof ? '0 : r_col;
        w_row_eff = sof ? '0 : r_row;
        w_wrap    = (w_col_eff == c_col_max) && (w_row_eff == c_row_max);
        w_col_nxt = (w_col_eff == c_col_max) ? '0 : w_col_eff + c_col_w'(1);
        w_row_nxt = w_row_eff;
        if (w_col_eff == c_col_max) begin
            w_row_nxt = (w_row_eff == c_row_max) ? '0 : w_row_eff + c_row_w'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        if (pix_valid) begin
            w_emit = (w_col_eff >= c_col_full) &&
                     (((r_state == STREAM) && !sof) || (w_row_eff == c_row_full));
            if (w_wrap) begin
                w_state_next = FILL;
            end else if (w_row_eff == c_row_full) begin
                w_state_next = STREAM;
            end else if (sof) begin
                w_state_next = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            en_out    <= 1'b0;
            data2conv <= '0;
        end else begin
            en_out <= w_emit;
            if (pix_valid) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
            end
            if (w_emit) begin
                data2conv <= w_win_flat;
            end
        end
    end

    // Window storage is masked by the emit gate, so it needs no reset.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_win <= w_win_next;
        end
    end

`ifdef CONV_WIN_LAST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            win_last <= 1'b0;
        end else begin
            win_last <= w_emit && w_wrap;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Sliding-window generator that feeds the convolution datapath.
- Accepts a raster-order pixel stream, one pixel per accepted beat.
- Holds KERNEL-1 line buffers plus a KERNEL x KERNEL window register.
- Emits one packed KERNEL*KERNEL window with a one-cycle enable for every valid (unpadded) output position.
- data2conv/en_out connect directly to the conv calc block's data2conv/en_in. No backpressure: the downstream accepts every window.

Parameters:
KERNEL, 3, window side (1/3/5/7); must match the conv calc block
N, 4, pixel data width
IMG_W, 8, image width in pixels (>= KERNEL)
IMG_H, 8, image height in rows (>= KERNEL)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
pix_in  input  N  pixel data, raster order (row-major, left to right)
pix_valid  input  1  pix_in accepted this cycle when high
sof  input  1  start of frame; qualified by pix_valid; marks the pixel as (row 0, col 0)
data2conv  output  KERNEL*KERNEL*N  packed window
en_out  output  1  one-cycle strobe, data2conv valid

Behaviour:
- Single clock. Reset is synchronous and active-high on rst.
- Reset state: data2conv=0, en_out=0, col=0, row=0, FSM=FILL. Line-buffer contents are don't-care; gating makes them unobservable.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 identify the pixel being accepted.
  - Both counters advance only on pix_valid.
  - col wraps at IMG_W-1 and increments row.
  - At (IMG_W-1, IMG_H-1), both wrap to 0 and a new frame begins implicitly.
- sof with pix_valid: the beat is treated as (0,0) regardless of the counters. The FSM returns to FILL and emits no window until refilled. This resynchronises a mid-frame restart.
- pix_valid low: everything holds, en_out=0. Gaps of any length are allowed.
- FSM states:
  - FILL: row < KERNEL-1. No windows emitted. Moves to STREAM on the first accepted beat with row == KERNEL-1.
  - STREAM: windows emitted when col >= KERNEL-1. Moves to FILL on frame wrap or sof.
- Window packing: element i = r*KERNEL + c occupies data2conv[i*N +: N].
  - r=0 is the oldest (top) row; r=KERNEL-1 is the current row.
  - c=0 is the leftmost (oldest) column.
  - Weight packing in the conv calc block uses the same index.
- Latency: the window completed by the pixel at (row, col) appears with en_out=1 exactly one cycle after that pixel is accepted. data2conv holds its value until the next window.
- Window count per frame: (IMG_W-KERNEL+1)*(IMG_H-KERNEL+1). Windows never straddle a row wrap, because the col >= KERNEL-1 gate blocks them.
- KERNEL=1: no line buffers. Every accepted pixel yields a window one cycle later.
- Reset mid-frame: outputs clear next cycle and the partial frame is discarded.
- Arithmetic: counter widths are clog2(IMG_W) and clog2(IMG_H). There is no data arithmetic; pixels are stored bit-exact.

Optional Feature:
CONV_WIN_LAST_EN:
- Defined: adds output port win_last (1 bit, reset 0). It is high together with en_out only for the window at (row IMG_H-1, col IMG_W-1) of a frame, and 0 otherwise.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package conv_pkg holds:
  - the clog2 function
  - FSM state encoding constants (FILL=0, STREAM=1)
  - the window-index helper (r*KERNEL+c)
  It is shared with other conv blocks.
- One natural sub-module, conv_line_buf: an IMG_W-deep, N-wide shift register advanced on pix_valid.
  - Instantiated KERNEL-1 times and chained row to row.
  - Its tap feeds column KERNEL-1 of the window register.

Test Plan:
1. KERNEL=3, N=4, IMG_W=5, IMG_H=4; pixels (row*5+col) mod 16, continuous pix_valid, sof on the first pixel.
   - Exactly 6 en_out pulses.
   - First pulse one cycle after pixel 12 is accepted, with window {0,1,2,5,6,7,10,11,12} at elements 0..8.
2. Same frame with pix_valid toggling 1-0-0-1.
   - Same 6 windows with the same contents.
   - en_out never high during a gap cycle.
   - Each pulse one cycle after its completing pixel.
3. Two back-to-back frames with no sof on the second.
   - 12 windows total.
   - Second frame's first window is {0,1,2,5,6,7,10,11,12} again, i.e. no stale rows leak across the frame boundary.
4. sof asserted at pixel 8 of a frame.
   - No window until the new frame's pixel 12 equivalent.
   - Then the correct window of the new frame.
5. rst asserted for one cycle after pixel 13.
   - data2conv=0 and en_out=0 on the next cycle.
   - The following frame (with sof) reproduces scenario 1 exactly.
6. With CONV_WIN_LAST_EN defined, scenario 1.
   - win_last high only with the 6th en_out pulse (window ending in pixel 19 mod 16 = 3).
   - Low otherwise and after reset.
